wl_bitplane_seq: RTL

- Upstream feeder of the DAC control stage in the CIM wordline chain.
- Captures one input vector of NUM_INPUTS pixels, PIXEL_BITS each, then issues it MSB-first as PIXEL_BITS bit-planes.
- Per plane: drives wl_bitmap with wl_valid_pulse, waits for the DAC done pulse, fires cim_start_pulse, waits for cim_done_pulse, then moves to the next plane.
- plane_idx and plane_last let the downstream shift-accumulate weight each plane's result.

---
 rtl/snn_soc_pkg.sv | 14 +
 rtl/bitplane_mux.sv | 40 ++++
 rtl/wl_bitplane_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/snn_soc_pkg.sv
// +----------------------------------------------------------------------+
// | snn_soc_pkg : shared SoC-wide sizing constants for the CIM datapath  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package snn_soc_pkg;
  localparam int NUM_INPUTS  = 64;
  localparam int PIXEL_BITS  = 8;
  // Never zero so a single-plane build still has a 1-bit plane index.
  localparam int PLANE_IDX_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
endpackage

`default_nettype wire

// File: rtl/bitplane_mux.sv
// +----------------------------------------------------------------------+
// | bitplane_mux : selects one bit-plane (one bit of every pixel) out of  |
// | a packed pixel vector; with WL_ZERO_SKIP_EN also flags non-zero planes|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bitplane_mux #(
  parameter int NUM_INPUTS = 64,
  parameter int PIXEL_BITS = 8,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_INPUTS*PIXEL_BITS-1:0] i_data,
  input  logic [IDX_W-1:0]                 i_idx,
  output logic [NUM_INPUTS-1:0]            o_plane
`ifdef WL_ZERO_SKIP_EN
  ,
  output logic [PIXEL_BITS-1:0]            o_nz
`endif
);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_pix
    logic [PIXEL_BITS-1:0] w_pix;
    assign w_pix      = i_data[i*PIXEL_BITS +: PIXEL_BITS];
    assign o_plane[i] = w_pix[i_idx];
  end

`ifdef WL_ZERO_SKIP_EN
  for (genvar p = 0; p < PIXEL_BITS; p++) begin : g_nz
    logic [NUM_INPUTS-1:0] w_bits;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
      assign w_bits[i] = i_data[i*PIXEL_BITS + p];
    end
    assign o_nz[p] = |w_bits;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/wl_bitplane_seq.sv
// +----------------------------------------------------------------------+
// | wl_bitplane_seq : issues a captured pixel vector MSB-first as bit-    |
// | planes, handshaking each plane with the DAC and CIM stages.          |
// | Optional macro WL_ZERO_SKIP_EN skips all-zero planes.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module wl_bitplane_seq #(
  parameter  int NUM_INPUTS = snn_soc_pkg::NUM_INPUTS,
  parameter  int PIXEL_BITS = snn_soc_pkg::PIXEL_BITS,
  localparam int c_IDX_W    = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_pulse,
  input  logic [NUM_INPUTS*PIXEL_BITS-1:0] in_data,
  input  logic                             abort,
  input  logic                             dac_done_pulse,
  input  logic                             cim_done_pulse,
  output logic [NUM_INPUTS-1:0]            wl_bitmap,
  output logic                             wl_valid_pulse,
  output logic                             cim_start_pulse,
  output logic [c_IDX_W-1:0]               plane_idx,
  output logic                             plane_last,
  output logic                             busy,
  output logic                             done_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DAC = 2'd1,
    ST_WAIT_CIM = 2'd2
  } state_t;

  localparam logic [c_IDX_W-1:0] c_TOP_IDX = c_IDX_W'(PIXEL_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_ONE     = c_IDX_W'(1);

  state_t                          r_state, w_state_nxt;
  logic [NUM_INPUTS*PIXEL_BITS-1:0] r_in_buf, w_buf_nxt;
  logic [c_IDX_W-1:0]              r_plane_idx, w_idx_nxt;
  logic [NUM_INPUTS-1:0]           r_wl_bitmap, w_bitmap_nxt;
  logic                            r_valid, w_valid_nxt;
  logic                            r_cstart, w_cstart_nxt;
  logic                            r_done, w_done_nxt;

  logic [NUM_INPUTS*PIXEL_BITS-1:0] w_src;
  logic [c_IDX_W-1:0]              w_cand;
  logic [c_IDX_W-1:0]              w_sel;
  logic                            w_found;
  logic [NUM_INPUTS-1:0]           w_plane;

  // In IDLE the first plane comes straight from in_data so it is ready at T+1.
  assign w_src  = (r_state == ST_IDLE) ? in_data : r_in_buf;
  assign w_cand = (r_state == ST_IDLE) ? c_TOP_IDX : (r_plane_idx - c_ONE);

`ifdef WL_ZERO_SKIP_EN
  logic [PIXEL_BITS-1:0] w_nz;

  // Highest non-zero plane at or below the candidate.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int p = 0; p < PIXEL_BITS; p++) begin
      if ((p <= int'(w_cand)) && w_nz[p]) begin
        w_found = 1'b1;
        w_sel   = c_IDX_W'(p);
      end
    end
  end
`else
  assign w_found = 1'b1;
  assign w_sel   = w_cand;
`endif

  bitplane_mux #(
    .NUM_INPUTS (NUM_INPUTS),
    .PIXEL_BITS (PIXEL_BITS),
    .IDX_W      (c_IDX_W)
  ) u_mux (
    .i_data  (w_src),
    .i_idx   (w_sel),
    .o_plane (w_plane)
`ifdef WL_ZERO_SKIP_EN
    ,
    .o_nz    (w_nz)
`endif
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_in_buf;
    w_idx_nxt    = r_plane_idx;
    w_bitmap_nxt = r_wl_bitmap;
    w_valid_nxt  = 1'b0;
    w_cstart_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = '0;
      w_bitmap_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_pulse && !abort) begin
            w_buf_nxt = in_data;
            if (w_found) begin
              w_idx_nxt    = w_sel;
              w_bitmap_nxt = w_plane;
              w_valid_nxt  = 1'b1;
              w_state_nxt  = ST_WAIT_DAC;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        ST_WAIT_DAC: begin
          if (dac_done_pulse) begin
            w_cstart_nxt = 1'b1;
            w_state_nxt  = ST_WAIT_CIM;
          end
        end
        ST_WAIT_CIM: begin
          if (cim_done_pulse) begin
            if ((r_plane_idx == '0) || !w_found) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_idx_nxt    = w_sel;
              w_bitmap_nxt = w_plane;
              w_valid_nxt  = 1'b1;
              w_state_nxt  = ST_WAIT_DAC;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_buf    <= '0;
      r_plane_idx <= '0;
      r_wl_bitmap <= '0;
      r_valid     <= 1'b0;
      r_cstart    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_buf    <= w_buf_nxt;
      r_plane_idx <= w_idx_nxt;
      r_wl_bitmap <= w_bitmap_nxt;
      r_valid     <= w_valid_nxt;
      r_cstart    <= w_cstart_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign wl_bitmap       = r_wl_bitmap;
  assign wl_valid_pulse  = r_valid;
  assign cim_start_pulse = r_cstart;
  assign plane_idx       = r_plane_idx;
  assign busy            = (r_state != ST_IDLE);
  assign plane_last      = busy && (r_plane_idx == '0);
  assign done_pulse      = r_done;

endmodule

`default_nettype wire
